mul_div_unit: RTL and testbench

//  Multi-cycle 16-bit multiply/divide execute unit that sits directly downstream of the register file.
//  - Consumes read_data1/read_data2 as op_a/op_b.
//  - Returns results through the register file's write port in two back-to-back write cycles:
//    low product or quotient to the destination register, then high product or remainder to R0.
//  - Asserts busy so the control unit stalls issue while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/mul_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the multi-cycle multiply/divide unit.
// The optional signed mode is enabled with the SIGNED_MULDIV_EN macro.
package muldiv_pkg;

  localparam int MD_WIDTH = 16;
  localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    WB_DEST = 2'd2,
    WB_R0   = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Register file write-port codes
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_R0   = 2'b01;
  localparam logic [1:0] RW_DEST = 2'b11;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for MUL, restoring
// shift-subtract for DIV, on the {acc_hi, acc_lo} accumulator pair.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shl    = {acc_hi, acc_lo[WIDTH-1]};
    diff   = shl - {1'b0, operand};
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    if (op_div) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is a true borrow
      if (diff[WIDTH]) begin
        hi_nxt = shl[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle 16-bit multiply/divide unit writing results back through the
// register file port (dest, then R0). Signed mode guarded by SIGNED_MULDIV_EN.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [WIDTH-1:0]      write_data,
  output logic [WIDTH-1:0]      r0,
  output logic                  div_by_zero
);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    dbz_q;
  logic                    op_div_q;
  logic [WIDTH-1:0]        operand_q;
  logic [WIDTH-1:0]        acc_hi;
  logic [WIDTH-1:0]        acc_lo;
  logic [REG_ADDR_W-1:0]   dest_q;
  logic [WIDTH-1:0]        step_hi;
  logic [WIDTH-1:0]        step_lo;
  logic [WIDTH-1:0]        fix_hi;
  logic [WIDTH-1:0]        fix_lo;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic                    start_dbz;
  logic                    last_iter;

  assign start_dbz = (op[0] == OP_DIV) && (op_b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div  (op_div_q),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand_q),
    .hi_nxt  (step_hi),
    .lo_nxt  (step_lo)
  );

`ifdef SIGNED_MULDIV_EN
  logic a_neg;
  logic b_neg;
  logic neg_lo_q;
  logic neg_hi_q;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] s;
    s = v;
    return en ? -s : s;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    logic signed [2*WIDTH-1:0] s;
    s = v;
    return en ? -s : s;
  endfunction

  assign a_neg = op[1] & op_a[WIDTH-1];
  assign b_neg = op[1] & op_b[WIDTH-1];
  assign mag_a = neg_w(op_a, a_neg);
  assign mag_b = neg_w(op_b, b_neg);

  // Product negates as one 2*WIDTH value; quotient and remainder fix up independently
  always_comb begin
    {fix_hi, fix_lo} = neg_2w({step_hi, step_lo}, neg_lo_q);
    if (op_div_q) begin
      fix_lo = neg_w(step_lo, neg_lo_q);
      fix_hi = neg_w(step_hi, neg_hi_q);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
    end
  end
`else
  logic unused_sign_sel;

  assign unused_sign_sel = op[1];
  assign mag_a  = op_a;
  assign mag_b  = op_b;
  assign fix_hi = step_hi;
  assign fix_lo = step_lo;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      reg_write   <= RW_NONE;
      write_reg   <= '0;
      write_data  <= '0;
      r0          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      reg_write   <= RW_NONE;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            dbz_q <= start_dbz;
            state <= start_dbz ? WB_DEST : CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (last_iter) state <= WB_DEST;
        end
        WB_DEST: begin
          reg_write  <= RW_DEST;
          write_reg  <= dest_q;
          write_data <= acc_lo;
          state      <= WB_R0;
        end
        default: begin
          reg_write   <= RW_R0;
          r0          <= acc_hi;
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Operand capture and accumulator update; data path carries no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_div_q  <= op[0];
      dest_q    <= dest_reg;
      operand_q <= (op[0] == OP_DIV) ? mag_b : mag_a;
      acc_hi    <= start_dbz ? op_a : '0;
      acc_lo    <= start_dbz ? '1 : ((op[0] == OP_DIV) ? mag_a : mag_b);
    end else if (state == CALC) begin
      acc_hi <= last_iter ? fix_hi : step_hi;
      acc_lo <= last_iter ? fix_lo : step_lo;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expected write-backs,
// a negedge monitor pops and compares them as the DUT writes the register file.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [4:0]  dest_reg;
  logic        busy;
  logic        done;
  logic [1:0]  reg_write;
  logic [4:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] r0;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [4:0]  dest;
    logic        dbz;
    int          c0;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mul_div_unit #(.WIDTH(16), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .dest_reg    (dest_reg),
    .busy        (busy),
    .done        (done),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .r0          (r0),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every register-file write against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_write == 2'b11) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dest_write", {30'd0, reg_write}, 32'd0);
        end else begin
          chk("write_data", {16'd0, write_data}, {16'd0, exp_q[0].lo});
          chk("write_reg", {27'd0, write_reg}, {27'd0, exp_q[0].dest});
          chk("dest_latency", cyc - exp_q[0].c0, exp_q[0].lat);
          chk("done_early", {31'd0, done}, 32'd0);
        end
      end else if (reg_write == 2'b01) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_r0_write", {30'd0, reg_write}, 32'd0);
        end else begin
          chk("r0", {16'd0, r0}, {16'd0, exp_q[0].hi});
          chk("done", {31'd0, done}, 32'd1);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_q[0].dbz});
          chk("r0_latency", cyc - exp_q[0].c0, exp_q[0].lat + 1);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          void'(exp_q.pop_front());
        end
      end else begin
        if (reg_write != 2'b00) chk("reg_write_code", {30'd0, reg_write}, 32'd0);
        if (done) chk("stray_done", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] d, input logic [15:0] lo, input logic [15:0] hi,
                       input logic dbz, input bit interfere);
    exp_t e;
    int   n;
    e.lo = lo; e.hi = hi; e.dest = d; e.dbz = dbz;
    e.c0 = cyc + 1;
    e.lat = dbz ? 1 : 17;
    exp_q.push_back(e);
    start = 1'b1; op = o; op_a = a; op_b = b; dest_reg = d;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (interfere) begin
      repeat (3) @(negedge clk);
      start = 1'b1; op = ~o; op_a = ~a; op_b = b ^ 16'h5A5A; dest_reg = ~d;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; dest_reg = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_reg_write", {30'd0, reg_write}, 32'd0);
    chk("rst_write_data", {16'd0, write_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 16'h00FF, 16'h0051, 5'd3,  16'h50AF, 16'h0000, 1'b0, 1'b0);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 5'd7,  16'h0001, 16'hFFFE, 1'b0, 1'b0);
    issue(2'b01, 16'h6666, 16'h0011, 5'd9,  16'h0606, 16'h0000, 1'b0, 1'b0);
    issue(2'b01, 16'h3099, 16'h0000, 5'd12, 16'hFFFF, 16'h3099, 1'b1, 1'b0);
    issue(2'b01, 16'h1234, 16'h0100, 5'd31, 16'h0012, 16'h0034, 1'b0, 1'b1);
    issue(2'b00, 16'h1234, 16'h0000, 5'd1,  16'h0000, 16'h0000, 1'b0, 1'b1);
    issue(2'b01, 16'h0005, 16'h0007, 5'd0,  16'h0000, 16'h0005, 1'b0, 1'b0);
    issue(2'b01, 16'hFFFF, 16'h0001, 5'd4,  16'hFFFF, 16'h0000, 1'b0, 1'b0);
`ifdef SIGNED_MULDIV_EN
    issue(2'b10, 16'hFFFE, 16'h0003, 5'd5,  16'hFFFA, 16'hFFFF, 1'b0, 1'b0);
    issue(2'b11, 16'hFFF9, 16'h0002, 5'd6,  16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    issue(2'b11, 16'h8000, 16'hFFFF, 5'd8,  16'h8000, 16'h0000, 1'b0, 1'b0);
    issue(2'b10, 16'h8000, 16'h8000, 5'd10, 16'h0000, 16'h4000, 1'b0, 1'b0);
`else
    issue(2'b10, 16'hFFFE, 16'h0003, 5'd5,  16'hFFFA, 16'h0002, 1'b0, 1'b0);
    issue(2'b11, 16'hFFF9, 16'h0002, 5'd6,  16'h7FFC, 16'h0001, 1'b0, 1'b0);
`endif

    // Abort: second start at cycle 5 ignored, reset at cycle 8 kills the op
    start = 1'b1; op = 2'b00; op_a = 16'h1111; op_b = 16'h2222; dest_reg = 5'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op_a = 16'h3333;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_reg_write", {30'd0, reg_write}, 32'd0);
    chk("abort_write_reg", {27'd0, write_reg}, 32'd0);
    chk("abort_write_data", {16'd0, write_data}, 32'd0);
    chk("abort_r0", {16'd0, r0}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    issue(2'b00, 16'h0003, 16'h0004, 5'd11, 16'h000C, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
